// File: rtl/jk_ff_using_dff.sv
// Bank of WIDTH independent JK flip-flops: a D register fed by next_q = (j & ~q) | (~k & q).
// Define JK_FF_USING_DFF_CHANGE_EN to add the registered per-bit 'changed' flag.
module jk_ff_using_dff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
`ifdef JK_FF_USING_DFF_CHANGE_EN
  ,
  output logic [WIDTH-1:0] changed
`endif
);

  logic [WIDTH-1:0] next_q;

  // hold / reset / set / toggle all fall out of this one bitwise equation
  assign next_q = (j & ~q) | (~k & q);

  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VAL;
    else     q <= next_q;
  end

  // derived from q rather than registered so the pair can never disagree
  assign q_n = ~q;

`ifdef JK_FF_USING_DFF_CHANGE_EN
  always_ff @(posedge clk) begin
    if (rst) changed <= '0;
    else     changed <= next_q ^ q;
  end
`endif

endmodule

// File: tb/tb_jk_ff_using_dff.sv
// Scoreboard bench: a 4-bit bank with RESET_VAL=0 and a 1-bit bank with RESET_VAL=1.
module tb_jk_ff_using_dff;

  typedef struct {
    logic [3:0] q;
    logic [3:0] ch;
    logic       qb;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] j = '0, k = '0, q, q_n;
  logic       jb = 1'b0, kb = 1'b0, qb, qb_n;
`ifdef JK_FF_USING_DFF_CHANGE_EN
  logic [3:0] changed;
  logic       changed_b;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  jk_ff_using_dff #(.WIDTH(4), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .q_n(q_n)
`ifdef JK_FF_USING_DFF_CHANGE_EN
    , .changed(changed)
`endif
  );

  jk_ff_using_dff #(.WIDTH(1), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .j(jb), .k(kb), .q(qb), .q_n(qb_n)
`ifdef JK_FF_USING_DFF_CHANGE_EN
    , .changed(changed_b)
`endif
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // drive on the falling edge; expectation is for the state after the next rising edge
  task automatic step(input logic r, input logic [3:0] jv, input logic [3:0] kv,
                      input logic jbv, input logic kbv,
                      input logic [3:0] eq, input logic [3:0] ech, input logic eqb,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst = r; j = jv; k = kv; jb = jbv; kb = kbv;
    e.q = eq; e.ch = ech; e.qb = eqb; e.name = name;
    sb.push_back(e);
  endtask

  // monitor: the registers present a new result after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".q"},    q,              e.q);
        check({e.name, ".q_n"},  q_n,            ~e.q);
        check({e.name, ".qb"},   {3'b000, qb},   {3'b000, e.qb});
        check({e.name, ".qb_n"}, {3'b000, qb_n}, {3'b000, ~e.qb});
`ifdef JK_FF_USING_DFF_CHANGE_EN
        check({e.name, ".changed"}, changed, e.ch);
`endif
      end
    end
  end

  initial begin
    //    rst  j        k        jb    kb    q        changed  qb
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, "reset");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, "hold_after_reset");
    step(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, "k_only");
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, "j_only");
    step(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0, "toggle1");
    step(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, "toggle2");
    step(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, "reset_after_toggle");
    step(1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1, "preload_0101");
    step(1'b0, 4'b0011, 4'b1010, 1'b0, 1'b1, 4'b0111, 4'b0010, 1'b0, "mixed_bits");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0, "hold_multi");
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 4'b1111, 1'b1, "toggle_all");
    // reset pulse confined to the low phase must be ignored
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, "rst_glitch");
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    // reset asserted after the falling edge: no effect until the rising edge
    step(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, "sync_reset");
    #2;
    check("sync_reset_midcycle.q",  q,            4'b1000);
    check("sync_reset_midcycle.qb", {3'b000, qb}, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, "set_after_reset");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, "changed_one_cycle");
    stim_done = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(stim_done && sb.size() == 0) && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    if (sb.size() != 0 || !stim_done) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
